// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RISC-V constants and fetch types
package riscv_pkg;

  localparam int unsigned      XLEN             = 32;
  localparam logic [XLEN-1:0]  RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0]  NOP              = 32'h0000_0013;

  // One fetched instruction together with the address it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Instruction addresses are word aligned; low two bits are forced to zero.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~32'h3;
  endfunction

endpackage

// File: rtl/if_fifo.sv
// rtl/if_fifo.sv - synchronous {pc, instr} queue for the fetch stage
//
// Purpose: DEPTH-entry FIFO holding fetched instructions until decode takes
// them. Push and pop may happen in the same cycle, even when full. Flush
// empties the queue and wins over push/pop.
//
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   flush_i       drop all entries
//   push_i        write push_data_i at the tail
//   push_data_i   entry to write
//   pop_i         remove the head entry
//   head_o        current head entry (undefined while count_o == 0)
//   count_o       number of valid entries, 0..DEPTH
module if_fifo
  import riscv_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o
);

  localparam logic [CW-1:0] FULL = DEPTH[CW-1:0];

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && ((count_q != FULL) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with credit-based queue
//
// Purpose: issues sequential instruction fetches, queues returned words with
// their addresses, presents them to decode, and handles redirects by
// flushing the queue and discarding responses still in flight.
//
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   imem_req_valid/ready/addr         fetch request handshake and address
//   imem_rsp_valid/data               in-order instruction responses
//   redirect_valid/pc                 branch/jump redirect from execute
//   out_valid/ready/pc/instr          instruction stream to decode
//   pc_current                        next fetch address
module if_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] pc_current
);

  localparam int unsigned   CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   CREDITS = DEPTH[CW:0];

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  // Address of the next response that will be kept. Responses return in
  // order and every stale one is discarded, so this simply follows the
  // fetch stream from the last redirect target.
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credit_used;
  logic            req_hs;
  logic            rsp_take;
  logic            push;
  logic            pop;
  fetch_entry_t    head;

  // Every outstanding request, stale or not, holds a queue slot, so a
  // returning response can never find the queue full.
  assign credit_used    = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign imem_req_valid = rst && !redirect_valid && (credit_used < CREDITS);
  assign imem_req_addr  = fetch_pc_q;
  assign pc_current     = fetch_pc_q;

  assign req_hs   = imem_req_valid && imem_req_ready;
  assign rsp_take = imem_rsp_valid && (inflight_q != '0);
  assign push     = rsp_take && (discard_q == '0) && !redirect_valid;
  assign out_valid = (fifo_count != '0);
  assign pop      = out_valid && out_ready && !redirect_valid;
  assign out_pc    = out_valid ? head.pc    : '0;
  assign out_instr = out_valid ? head.instr : '0;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q + CW'(req_hs) - CW'(rsp_take);
    discard_d  = discard_q;
    if (redirect_valid) begin
      fetch_pc_d = align_pc(redirect_pc);
      rsp_pc_d   = align_pc(redirect_pc);
      // Everything still outstanding after this edge is stale, including
      // requests already marked by an earlier redirect.
      discard_d  = inflight_q - CW'(rsp_take);
    end else begin
      if (req_hs) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push)   rsp_pc_d   = rsp_pc_q + 32'd4;
      if (rsp_take && (discard_q != '0)) discard_d = discard_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  if_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i ('{pc: rsp_pc_q, instr: imem_rsp_data}),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  // A response with nothing outstanding is a memory-side protocol error.
  rsp_without_request : assert property (
    @(posedge clk) disable iff (!rst) !(imem_rsp_valid && (inflight_q == '0))
  );

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage
module tb_if_stage;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] pc_current;

  always #5 clk = ~clk;

  if_stage #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr), .pc_current(pc_current)
  );

  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [31:0] pc; bit disc; } inf_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int mem_lat = 1;

  ent_t        mq[$];
  inf_t        minf[$];
  pend_t       pend[$];
  logic [31:0] mpc = 32'h0;
  ent_t        seen[$];
  int          seen_cyc[$];
  logic [31:0] reqs[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h1000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    minf.delete();
    pend.delete();
    mpc = 32'h0;
  endtask

  function automatic bit m_req();
    return rst && !redirect_valid && ((minf.size() + mq.size()) < DEPTH);
  endfunction

  // Behaviour at one clock edge: outstanding requests are a list of
  // addresses, each possibly marked stale; the queue is a list of entries.
  task automatic model_step();
    bit   hs;
    bit   rsp;
    inf_t e;
    hs  = m_req() && imem_req_ready;
    rsp = imem_rsp_valid && (minf.size() > 0);
    if (redirect_valid) begin
      if (rsp) void'(minf.pop_front());
      foreach (minf[i]) minf[i].disc = 1'b1;
      mq.delete();
      mpc = redirect_pc & ~32'h3;
    end else begin
      if ((mq.size() > 0) && out_ready) void'(mq.pop_front());
      if (rsp) begin
        e = minf.pop_front();
        if (!e.disc) mq.push_back('{e.pc, imem_rsp_data});
      end
      if (hs) begin
        minf.push_back('{mpc, 1'b0});
        mpc = mpc + 32'd4;
      end
    end
  endtask

  task automatic tick();
    bit          dhs;
    logic [31:0] daddr;
    @(negedge clk);
    chk("out_valid", {31'h0, out_valid}, {31'h0, mq.size() > 0});
    chk("out_pc", out_pc, (mq.size() > 0) ? mq[0].pc : 32'h0);
    chk("out_instr", out_instr, (mq.size() > 0) ? mq[0].instr : 32'h0);
    chk("req_valid", {31'h0, imem_req_valid}, {31'h0, m_req()});
    chk("req_addr", imem_req_addr, mpc);
    chk("pc_current", pc_current, mpc);
    dhs   = imem_req_valid && imem_req_ready;
    daddr = imem_req_addr;
    if (dhs) reqs.push_back(daddr);
    if (rst && out_valid && out_ready && !redirect_valid) begin
      seen.push_back('{out_pc, out_instr});
      seen_cyc.push_back(cyc);
    end
    @(posedge clk);
    if (!rst) model_reset();
    else begin
      model_step();
      if (dhs) pend.push_back('{daddr, cyc + mem_lat});
    end
    cyc++;
    #1;
    if (rst && (pend.size() > 0) && (pend[0].due <= cyc)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    model_reset();
    #1;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_pc_current", pc_current, 32'h0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("req_after_reset", {31'h0, imem_req_valid}, 32'h1);

    // Streaming from reset at full rate.
    seen.delete();
    seen_cyc.delete();
    repeat (8) tick();
    chk("A_pc0", seen[0].pc, 32'h0);
    chk("A_instr0", seen[0].instr, 32'h1000_0013);
    chk("A_pc1", seen[1].pc, 32'h4);
    chk("A_instr1", seen[1].instr, 32'h1000_0017);
    chk("A_pc2", seen[2].pc, 32'h8);
    chk("A_instr2", seen[2].instr, 32'h1000_001B);
    chk("A_consec1", seen_cyc[1] - seen_cyc[0], 32'd1);
    chk("A_consec2", seen_cyc[2] - seen_cyc[0], 32'd2);

    // Decode stalled: credits limit fetch to DEPTH requests.
    out_ready = 1'b0;
    redirect_to(32'h40);
    reqs.delete();
    repeat (10) tick();
    chk("B_nreq", reqs.size(), DEPTH);
    chk("B_req_low", {31'h0, imem_req_valid}, 32'h0);
    chk("B_hold_pc", out_pc, 32'h40);
    chk("B_hold_instr", out_instr, 32'h1000_0053);
    out_ready = 1'b1;
    seen.delete();
    repeat (8) tick();
    chk("B_rel0", seen[0].pc, 32'h40);
    chk("B_rel1", seen[1].pc, 32'h44);
    chk("B_rel2", seen[2].pc, 32'h48);
    chk("B_rel3", seen[3].pc, 32'h4C);

    // Redirect with two requests in flight.
    mem_lat = 2;
    for (int i = 0; i < 20; i++) begin
      if ((minf.size() == 2) && !minf[0].disc && !minf[1].disc) break;
      tick();
    end
    chk("C_two_inflight", minf.size(), 32'd2);
    redirect_to(32'h100);
    chk("C_out_valid_low", {31'h0, out_valid}, 32'h0);
    seen.delete();
    repeat (10) tick();
    chk("C_first_pc", seen[0].pc, 32'h100);
    chk("C_first_instr", seen[0].instr, 32'h1000_0113);
    chk("C_second_pc", seen[1].pc, 32'h104);

    // Misaligned target, then wrap at the top of the address space.
    mem_lat = 1;
    redirect_to(32'h203);
    chk("D_aligned", imem_req_addr, 32'h200);
    repeat (6) tick();
    reqs.delete();
    seen.delete();
    redirect_to(32'hFFFF_FFFC);
    repeat (8) tick();
    chk("D_req0", reqs[0], 32'hFFFF_FFFC);
    chk("D_req1", reqs[1], 32'h0);
    chk("D_seen0", seen[0].pc, 32'hFFFF_FFFC);
    chk("D_seen0_instr", seen[0].instr, 32'h1000_000F);
    chk("D_seen1", seen[1].pc, 32'h0);
    for (int i = 0; i < 6; i++) begin
      imem_req_ready = i[0];
      tick();
    end
    imem_req_ready = 1'b1;

    // Redirect coinciding with a response and a decode handshake.
    for (int i = 0; i < 20; i++) begin
      if (imem_rsp_valid && (mq.size() > 0)) break;
      tick();
    end
    chk("E_setup", {31'h0, imem_rsp_valid && out_valid}, 32'h1);
    redirect_to(32'h300);
    chk("E_out_valid_low", {31'h0, out_valid}, 32'h0);
    seen.delete();
    repeat (6) tick();
    chk("E_first_pc", seen[0].pc, 32'h300);

    // Reset with the queue full.
    out_ready = 1'b0;
    repeat (12) tick();
    chk("F_full", {31'h0, out_valid}, 32'h1);
    rst = 1'b0;
    model_reset();
    imem_rsp_valid = 1'b0;
    #1;
    chk("F_out_valid", {31'h0, out_valid}, 32'h0);
    chk("F_out_pc", out_pc, 32'h0);
    chk("F_out_instr", out_instr, 32'h0);
    chk("F_req_valid", {31'h0, imem_req_valid}, 32'h0);
    chk("F_req_addr", imem_req_addr, 32'h0);
    chk("F_pc_current", pc_current, 32'h0);
    tick();
    tick();
    rst = 1'b1;
    out_ready = 1'b1;
    reqs.delete();
    seen.delete();
    #1;
    chk("F_restart_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("F_restart_addr", imem_req_addr, 32'h0);
    repeat (6) tick();
    chk("F_req0", reqs[0], 32'h0);
    chk("F_seen0", seen[0].pc, 32'h0);
    chk("F_seen0_instr", seen[0].instr, 32'h1000_0013);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
